// File: rtl/ec_resource_arb.sv
// Round-robin share of one mod-P arithmetic unit between NUM_IN requesters.
// Issues at most MAX_OUTST operations and routes results back by the ID tag in the upper ctl bits.
module ec_resource_arb #(
  parameter int NUM_IN    = 3,
  parameter int DAT_BITS  = 762,
  parameter int RES_BITS  = 381,
  parameter int CTL_BITS  = 8,
  parameter int MAX_OUTST = 8,
  localparam int ID_BITS  = $clog2(NUM_IN)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_IN-1:0]            i_req_val,
  input  logic [NUM_IN*DAT_BITS-1:0]   i_req_dat,
  input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
  output logic [NUM_IN-1:0]            o_req_rdy,
  output logic                         o_rsc_val,
  output logic [DAT_BITS-1:0]          o_rsc_dat,
  output logic [CTL_BITS+ID_BITS-1:0]  o_rsc_ctl,
  input  logic                         i_rsc_rdy,
  input  logic                         i_rsc_val,
  input  logic [RES_BITS-1:0]          i_rsc_dat,
  input  logic [CTL_BITS+ID_BITS-1:0]  i_rsc_ctl,
  output logic                         o_rsc_rdy,
  output logic [NUM_IN-1:0]            o_rsp_val,
  output logic [RES_BITS-1:0]          o_rsp_dat,
  output logic [CTL_BITS-1:0]          o_rsp_ctl,
  input  logic [NUM_IN-1:0]            i_rsp_rdy,
  output logic                         o_err
);
  localparam int CNT_BITS = $clog2(MAX_OUTST + 1);

  logic [NUM_IN-1:0][DAT_BITS-1:0] req_dat;
  logic [NUM_IN-1:0][CTL_BITS-1:0] req_ctl;
  logic [ID_BITS-1:0]  ptr, gnt_id, idx, rsp_id, rsc_id;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS:0]   cnt_nxt;
  logic gnt, can_issue, rsc_free, rsp_full, rsp_hs, rsc_acc, bad_id;

  assign req_dat = i_req_dat;
  assign req_ctl = i_req_ctl;

  assign rsc_free  = ~o_rsc_val | i_rsc_rdy;
  assign can_issue = ~i_rst & rsc_free & (cnt < CNT_BITS'(MAX_OUTST));

  // first valid channel at or above the pointer, wrapping
  always_comb begin
    gnt    = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int off = 0; off < NUM_IN; off++) begin
      idx = ID_BITS'((int'(ptr) + off) % NUM_IN);
      if (!gnt && i_req_val[idx]) begin
        gnt    = 1'b1;
        gnt_id = idx;
      end
    end
    gnt = gnt & can_issue;
  end

  always_comb begin
    o_req_rdy = '0;
    if (gnt) o_req_rdy[gnt_id] = 1'b1;
  end

  assign rsc_id    = i_rsc_ctl[CTL_BITS +: ID_BITS];
  assign bad_id    = int'(rsc_id) >= NUM_IN;
  assign rsp_hs    = rsp_full & i_rsp_rdy[rsp_id];
  assign o_rsc_rdy = ~i_rst & (~rsp_full | i_rsp_rdy[rsp_id]);
  assign rsc_acc   = i_rsc_val & o_rsc_rdy;

  always_comb begin
    o_rsp_val = '0;
    if (rsp_full) o_rsp_val[rsp_id] = 1'b1;
  end

  // a dropped (bad ID) result retires its slot just like a delivered one
  always_comb begin
    cnt_nxt = {1'b0, cnt} + (CNT_BITS+1)'(gnt) - (CNT_BITS+1)'(rsp_hs)
            - (CNT_BITS+1)'(rsc_acc & bad_id);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsc_val <= 1'b0;
      o_rsc_dat <= '0;
      o_rsc_ctl <= '0;
      ptr       <= '0;
      cnt       <= '0;
      rsp_full  <= 1'b0;
      rsp_id    <= '0;
      o_rsp_dat <= '0;
      o_rsp_ctl <= '0;
      o_err     <= 1'b0;
    end else begin
      if (rsc_free) begin
        o_rsc_val <= gnt;
        if (gnt) begin
          o_rsc_dat <= req_dat[gnt_id];
          o_rsc_ctl <= {gnt_id, req_ctl[gnt_id]};
          ptr       <= ID_BITS'((int'(gnt_id) + 1) % NUM_IN);
        end
      end
      if (rsp_hs) rsp_full <= 1'b0;
      if (rsc_acc && !bad_id) begin
        rsp_full  <= 1'b1;
        rsp_id    <= rsc_id;
        o_rsp_dat <= i_rsc_dat;
        o_rsp_ctl <= i_rsc_ctl[CTL_BITS-1:0];
      end
      o_err <= rsc_acc & bad_id;
      // underflow only possible with rogue returns; hold at zero
      cnt   <= cnt_nxt[CNT_BITS] ? '0 : cnt_nxt[CNT_BITS-1:0];
    end
  end
endmodule

// File: tb/tb_ec_resource_arb.sv
// Scoreboard bench for ec_resource_arb: transaction-level model of arbitration,
// outstanding limit and tag routing, plus directed corner cases and random traffic.
module tb_ec_resource_arb;
  localparam int N = 3, DW = 762, RW = 381, CW = 8, MO = 8, IW = 2;
  typedef logic [1023:0] w_t;
  typedef struct { int ch; logic [CW-1:0] ctl; logic [DW-1:0] dat; } op_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      req_val, req_rdy, rsp_val, rsp_rdy;
  logic [N*DW-1:0]   req_dat;
  logic [N*CW-1:0]   req_ctl;
  logic              rsc_val_o, rsc_rdy_i, rsc_val_i, rsc_rdy_o, err;
  logic [DW-1:0]     rsc_dat_o;
  logic [CW+IW-1:0]  rsc_ctl_o, rsc_ctl_i;
  logic [RW-1:0]     rsc_dat_i, rsp_dat;
  logic [CW-1:0]     rsp_ctl;

  ec_resource_arb #(.NUM_IN(N), .DAT_BITS(DW), .RES_BITS(RW), .CTL_BITS(CW), .MAX_OUTST(MO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(req_val), .i_req_dat(req_dat), .i_req_ctl(req_ctl), .o_req_rdy(req_rdy),
    .o_rsc_val(rsc_val_o), .o_rsc_dat(rsc_dat_o), .o_rsc_ctl(rsc_ctl_o), .i_rsc_rdy(rsc_rdy_i),
    .i_rsc_val(rsc_val_i), .i_rsc_dat(rsc_dat_i), .i_rsc_ctl(rsc_ctl_i), .o_rsc_rdy(rsc_rdy_o),
    .o_rsp_val(rsp_val), .o_rsp_dat(rsp_dat), .o_rsp_ctl(rsp_ctl), .i_rsp_rdy(rsp_rdy),
    .o_err(err)
  );

  int checks = 0, fails = 0;
  function automatic void chk(string nm, w_t act, w_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // the bench's resource: result is the xor of the two packed field elements
  function automatic logic [RW-1:0] f(input logic [DW-1:0] d);
    return d[RW-1:0] ^ d[DW-1:RW];
  endfunction

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 24; i++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  // reference model state
  int m_ptr, m_cnt;
  bit m_rfull, m_err, hs_acc;
  logic [N-1:0] hs_req;
  op_t exp_rsc[$], exp_rsp[$], res_q[$];

  // stimulus state
  op_t cur[N];
  op_t ret_cur;
  logic [IW-1:0] ret_id;
  int req_pct, ret_pct;
  bit rdy_rand;

  always @(negedge clk) begin : mon
    int pick, k;
    bit free, have, rhs, acc, bad;
    logic [N-1:0] e;
    op_t op;
    if (rst) begin
      chk("rst_req_rdy", w_t'(req_rdy), '0);
      chk("rst_rsc_val", w_t'(rsc_val_o), '0);
      chk("rst_rsc_rdy", w_t'(rsc_rdy_o), '0);
      chk("rst_rsp_val", w_t'(rsp_val), '0);
      chk("rst_err", w_t'(err), '0);
      chk("rst_rsc_dat", w_t'(rsc_dat_o), '0);
      m_ptr = 0; m_cnt = 0; m_rfull = 0; m_err = 0; hs_acc = 0; hs_req = '0;
      exp_rsc.delete(); exp_rsp.delete(); res_q.delete();
    end else begin
      free = !m_rfull || rsc_rdy_i;
      pick = -1;
      if (free && m_cnt < MO)
        for (int off = 0; off < N; off++) begin
          k = (m_ptr + off) % N;
          if (pick < 0 && req_val[k]) pick = k;
        end
      e = '0;
      if (pick >= 0) e[pick] = 1'b1;
      chk("req_rdy", w_t'(req_rdy), w_t'(e));
      chk("rsc_val", w_t'(rsc_val_o), w_t'(m_rfull));
      if (m_rfull && rsc_rdy_i) begin
        op = exp_rsc.pop_front();
        chk("rsc_ctl", w_t'(rsc_ctl_o), w_t'({IW'(op.ch), op.ctl}));
        chk("rsc_dat", w_t'(rsc_dat_o), w_t'(op.dat));
        res_q.push_back(op);
      end
      if (free) m_rfull = pick >= 0;
      if (pick >= 0) begin
        exp_rsc.push_back(cur[pick]);
        m_ptr = (pick + 1) % N;
      end
      hs_req = e;

      have = exp_rsp.size() > 0;
      e = '0;
      rhs = 0;
      if (have) begin
        e[exp_rsp[0].ch] = 1'b1;
        rhs = rsp_rdy[exp_rsp[0].ch];
        chk("rsp_dat", w_t'(rsp_dat), w_t'(f(exp_rsp[0].dat)));
        chk("rsp_ctl", w_t'(rsp_ctl), w_t'(exp_rsp[0].ctl));
      end
      chk("rsp_val", w_t'(rsp_val), w_t'(e));
      chk("rsc_rdy", w_t'(rsc_rdy_o), w_t'(!have || rhs));
      chk("err", w_t'(err), w_t'(m_err));
      acc = rsc_val_i && (!have || rhs);
      bad = acc && (int'(ret_id) >= N);
      if (rhs) void'(exp_rsp.pop_front());
      if (acc && !bad) exp_rsp.push_back(ret_cur);
      m_err  = bad;
      hs_acc = acc;
      m_cnt  = m_cnt + (pick >= 0 ? 1 : 0) - (rhs ? 1 : 0) - (bad ? 1 : 0);
    end
  end

  task automatic new_op(int k, logic [CW-1:0] ctl);
    cur[k].ch  = k;
    cur[k].ctl = ctl;
    cur[k].dat = rand_dat();
    req_val[k] = 1'b1;
    req_dat[k*DW +: DW] = cur[k].dat;
    req_ctl[k*CW +: CW] = ctl;
  endtask

  task automatic present(bit bad);
    ret_cur   = res_q.pop_front();
    ret_id    = bad ? IW'(3) : IW'(ret_cur.ch);
    rsc_val_i = 1'b1;
    rsc_dat_i = f(ret_cur.dat);
    rsc_ctl_i = {ret_id, ret_cur.ctl};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    req_val = req_val & ~hs_req;
    if (hs_acc) rsc_val_i = 1'b0;
    for (int k = 0; k < N; k++)
      if (req_pct > 0 && !req_val[k] && int'($urandom_range(99)) < req_pct) new_op(k, 8'($urandom));
    if (rdy_rand) begin
      rsc_rdy_i = $urandom_range(3) != 0;
      for (int k = 0; k < N; k++) rsp_rdy[k] = $urandom_range(3) != 0;
    end
    if (ret_pct > 0 && !rsc_val_i && res_q.size() > 0 && int'($urandom_range(99)) < ret_pct) present(0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_val = '0; rsc_val_i = 1'b0; rsc_rdy_i = 1'b0; rsp_rdy = '0;
    req_pct = 0; ret_pct = 0; rdy_rand = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rsc_rdy_i = 1'b1;
    rsp_rdy = '1;
  endtask

  task automatic wait_req(int k, string nm);
    int n = 0;
    while (req_val[k] && n < 50) begin cyc(); n++; end
    chk(nm, w_t'(req_val[k]), '0);
  endtask

  task automatic drain(string nm);
    int n = 0;
    req_pct = 0; rdy_rand = 0; rsc_rdy_i = 1'b1; rsp_rdy = '1; ret_pct = 100;
    while ((exp_rsc.size() > 0 || exp_rsp.size() > 0 || res_q.size() > 0 || rsc_val_i || req_val != '0)
           && n < 500) begin
      cyc(); n++;
    end
    chk(nm, w_t'(n < 500), w_t'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1);
  end

  initial begin
    int n, g, gc, hc, ec, rc;
    op_t op1;
    req_val = '0; req_dat = '0; req_ctl = '0; rsc_dat_i = '0; rsc_ctl_i = '0; rsc_val_i = 1'b0;
    rsc_rdy_i = 1'b0; rsp_rdy = '0; ret_id = '0; req_pct = 0; ret_pct = 0; rdy_rand = 0;
    do_reset();

    // single channel round trip
    new_op(1, 8'h05);
    cyc();
    chk("single_val", w_t'(rsc_val_o), w_t'(1));
    chk("single_ctl", w_t'(rsc_ctl_o), w_t'(10'h105));
    ret_pct = 100;
    n = 0;
    while (rsp_val == '0 && n < 20) begin cyc(); n++; end
    chk("single_rsp_val", w_t'(rsp_val), w_t'(3'b010));
    chk("single_rsp_ctl", w_t'(rsp_ctl), w_t'(8'h05));
    drain("single_drain");

    // round robin with all channels valid
    do_reset();
    req_pct = 100;
    cyc();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), w_t'(req_rdy), w_t'(1 << (i % 3)));
      cyc();
    end

    // outstanding limit, then one return frees exactly one slot
    do_reset();
    req_pct = 100;
    cyc();
    g = 0;
    for (int i = 0; i < 14; i++) begin #1; if (req_rdy != '0) g++; cyc(); end
    chk("max_grants", w_t'(g), w_t'(8));
    #1;
    chk("max_rdy0", w_t'(req_rdy), '0);
    present(0);
    g = 0; gc = -1; hc = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if ((rsp_val & rsp_rdy) != '0 && hc < 0) hc = i;
      if (req_rdy != '0) begin g++; gc = i; end
      cyc();
    end
    chk("refill_grants", w_t'(g), w_t'(1));
    chk("refill_cycle", w_t'(gc), w_t'(hc + 1));
    drain("max_drain");

    // stalled requester back-pressures the resource
    do_reset();
    rsp_rdy = 3'b110;
    ret_pct = 100;
    new_op(0, 8'h11);
    op1 = cur[0];
    wait_req(0, "stall_req1");
    new_op(0, 8'h22);
    wait_req(0, "stall_req2");
    repeat (10) cyc();
    #1;
    chk("stall_rsc_rdy", w_t'(rsc_rdy_o), '0);
    chk("stall_rsp_val", w_t'(rsp_val), w_t'(3'b001));
    chk("stall_rsp_dat", w_t'(rsp_dat), w_t'(f(op1.dat)));
    chk("stall_rsp_ctl", w_t'(rsp_ctl), w_t'(8'h11));
    drain("stall_drain");

    // out-of-range ID: dropped, err pulse, slot released
    do_reset();
    new_op(2, 8'h3c);
    n = 0;
    while (res_q.size() == 0 && n < 20) begin cyc(); n++; end
    chk("bad_issued", w_t'(res_q.size() > 0), w_t'(1));
    if (res_q.size() > 0) present(1);
    ec = 0; rc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (err) ec++;
      if (rsp_val != '0) rc++;
      cyc();
    end
    chk("bad_err_pulses", w_t'(ec), w_t'(1));
    chk("bad_no_rsp", w_t'(rc), '0);
    req_pct = 100;
    g = 0;
    for (int i = 0; i < 14; i++) begin #1; if (req_rdy != '0) g++; cyc(); end
    chk("bad_slot_freed", w_t'(g), w_t'(8));
    drain("bad_drain");

    // asynchronous reset in the middle of traffic
    do_reset();
    req_pct = 70; ret_pct = 60; rdy_rand = 1;
    repeat (25) cyc();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_req_rdy", w_t'(req_rdy), '0);
    chk("arst_rsc_val", w_t'(rsc_val_o), '0);
    chk("arst_rsc_ctl", w_t'(rsc_ctl_o), '0);
    chk("arst_rsc_rdy", w_t'(rsc_rdy_o), '0);
    chk("arst_rsp_val", w_t'(rsp_val), '0);
    chk("arst_err", w_t'(err), '0);

    // random traffic against the model
    do_reset();
    req_pct = 40; ret_pct = 50; rdy_rand = 1;
    repeat (3000) cyc();
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
